// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the PC sequencer slice: the PC width, default
// boot/interrupt/step constants, the sequencer state type and a small
// helper for the sequential PC increment.
// No ports (package).

package pc_sequencer_pkg;

    localparam int PC_WIDTH = 32;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t DEFAULT_RESET_ADDR = 32'd107;
    localparam pc_t DEFAULT_IRQ_VECTOR = 32'd4;
    localparam pc_t DEFAULT_PC_STEP    = 32'd1;

    // Encodings are visible on the debug state output, so they are fixed.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    // The PC is a word index; the increment wraps naturally modulo 2^32.
    function automatic pc_t pc_increment(input pc_t pc, input pc_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles every signal between the PC sequencer and its surroundings
// (fetch handshake, branch/jump decode, PC register, debug outputs).
//   master modport: the sequencer (drives pc_next, pc_write, fetch_req,
//                   epc, retired, state; observes everything else)
//   slave modport : the surrounding datapath / environment
// Clock and reset are not part of the bundle.

interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    pc_t         pc_cur;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    pc_t         branch_target;
    logic        jump;
    pc_t         jump_target;
    logic        halt;
    logic        irq;
    logic        irq_en;

    pc_t         pc_next;
    logic        pc_write;
    logic        fetch_req;
    pc_t         epc;
    logic [31:0] retired;
    logic [1:0]  state;

    modport master (
        input  pc_cur, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt, irq, irq_en,
        output pc_next, pc_write, fetch_req, epc, retired, state
    );

    modport slave (
        output pc_cur, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt, irq, irq_en,
        input  pc_next, pc_write, fetch_req, epc, retired, state
    );

endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// pc_next_sel
// Fixed-priority next-PC multiplexer: interrupt vector, then jump target,
// then branch target, otherwise the sequential PC.
// Ports:
//   irq_take      in   accepted interrupt this cycle
//   jump          in   take jump_target
//   branch_taken  in   take branch_target
//   jump_target   in   jump destination
//   branch_target in   branch destination
//   pc_cur        in   current PC
//   pc_next       out  selected next PC

module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter pc_t IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
    parameter pc_t PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic irq_take,
    input  logic jump,
    input  logic branch_taken,
    input  pc_t  jump_target,
    input  pc_t  branch_target,
    input  pc_t  pc_cur,
    output pc_t  pc_next
);

    // Priority chain; the sequential PC is the fall-through default.
    always_comb begin
        pc_next = pc_increment(pc_cur, PC_STEP);
        if (irq_take) begin
            pc_next = IRQ_VECTOR;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Control FSM that decides when the PC register is loaded and with what:
// boot vector, fetch wait, stall, branch/jump redirect, a single interrupt
// vector with saved return address, halt, and a retired-instruction count.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low reset
//   bus    master modport of pc_sequencer_if (see that file)

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter pc_t RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter pc_t IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
    parameter pc_t PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    seq_state_t  state_q, state_d;
    pc_t         epc_q, epc_d;
    logic [31:0] retired_q, retired_d;

    logic        irq_req;
    logic        exec_go;
    logic        irq_take;
    logic        sel_jump;
    logic        sel_branch;
    pc_t         sel_pc;

    logic        pc_write_c;
    pc_t         pc_next_c;
    logic        fetch_req_c;

    // An instruction completes in EXEC only when not stalled. Interrupts are
    // accepted at that point or while halted. A halt that is not overridden
    // by an interrupt forces the sequential PC, so jump/branch are masked.
    assign irq_req    = bus.irq & bus.irq_en;
    assign exec_go    = (state_q == EXEC) & ~bus.stall;
    assign irq_take   = irq_req & (exec_go | (state_q == HALT));
    assign sel_jump   = bus.jump & exec_go & ~bus.halt;
    assign sel_branch = bus.branch_taken & exec_go & ~bus.halt;

    pc_next_sel #(
        .IRQ_VECTOR (IRQ_VECTOR),
        .PC_STEP    (PC_STEP)
    ) u_pc_next_sel (
        .irq_take      (irq_take),
        .jump          (sel_jump),
        .branch_taken  (sel_branch),
        .jump_target   (bus.jump_target),
        .branch_target (bus.branch_target),
        .pc_cur        (bus.pc_cur),
        .pc_next       (sel_pc)
    );

    // Next-state and output decode. pc_next defaults to pc_cur so that a
    // stalled or idle cycle presents the unchanged PC.
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        retired_d   = retired_q;
        pc_write_c  = 1'b0;
        pc_next_c   = bus.pc_cur;
        fetch_req_c = 1'b0;

        case (state_q)
            BOOT: begin
                pc_write_c = 1'b1;
                pc_next_c  = RESET_ADDR;
                state_d    = FETCH;
            end

            FETCH: begin
                fetch_req_c = 1'b1;
                if (bus.imem_ready) begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (!bus.stall) begin
                    pc_write_c = 1'b1;
                    pc_next_c  = sel_pc;
                    retired_d  = retired_q + 32'd1;
                    if (irq_take) begin
                        epc_d   = pc_increment(bus.pc_cur, PC_STEP);
                        state_d = FETCH;
                    end else if (bus.halt) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            HALT: begin
                // pc_cur already points past the halting instruction here.
                if (irq_take) begin
                    pc_write_c = 1'b1;
                    pc_next_c  = sel_pc;
                    epc_d      = bus.pc_cur;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, saved return PC and retired counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            epc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc_next   = pc_next_c;
    assign bus.pc_write  = pc_write_c;
    assign bus.fetch_req = fetch_req_c;
    assign bus.epc       = epc_q;
    assign bus.retired   = retired_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model of the sequencer's rules. The bench also
// models the PC register, feeding its value back as pc_cur in random runs.

module tb_pc_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'd107;
    localparam logic [31:0] IRQ_VEC    = 32'd4;
    localparam int S_BOOT  = 0;
    localparam int S_FETCH = 1;
    localparam int S_EXEC  = 2;
    localparam int S_HALT  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int compare_count = 0;
    int mismatch_count = 0;

    int          m_state;
    logic [31:0] m_epc;
    logic [31:0] m_retired;
    logic [31:0] m_pc;
    logic [31:0] last_pc_next;

    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h",
                     tag, observed, expected);
        end
    endtask

    // Called with inputs already driven just after a falling edge. Checks the
    // combinational outputs against the model, advances the model across the
    // next rising edge, and returns at the following falling edge.
    task automatic runCycle(input string tag);
        logic        e_wr;
        logic        e_fetch;
        logic [31:0] e_next;
        logic        take;
        int          n_state;
        logic [31:0] n_epc;
        logic [31:0] n_ret;

        #1;
        take    = bus.irq && bus.irq_en;
        e_wr    = 1'b0;
        e_fetch = 1'b0;
        e_next  = bus.pc_cur;
        n_state = m_state;
        n_epc   = m_epc;
        n_ret   = m_retired;

        case (m_state)
            S_BOOT: begin
                e_wr    = 1'b1;
                e_next  = RESET_ADDR;
                n_state = S_FETCH;
            end
            S_FETCH: begin
                e_fetch = 1'b1;
                if (bus.imem_ready) n_state = S_EXEC;
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    e_wr  = 1'b1;
                    n_ret = m_retired + 32'd1;
                    if (take) begin
                        e_next  = IRQ_VEC;
                        n_epc   = bus.pc_cur + 32'd1;
                        n_state = S_FETCH;
                    end else if (bus.halt) begin
                        e_next  = bus.pc_cur + 32'd1;
                        n_state = S_HALT;
                    end else begin
                        if (bus.jump)              e_next = bus.jump_target;
                        else if (bus.branch_taken) e_next = bus.branch_target;
                        else                       e_next = bus.pc_cur + 32'd1;
                        n_state = S_FETCH;
                    end
                end
            end
            default: begin
                if (take) begin
                    e_wr    = 1'b1;
                    e_next  = IRQ_VEC;
                    n_epc   = bus.pc_cur;
                    n_state = S_FETCH;
                end
            end
        endcase

        last_pc_next = bus.pc_next;
        checkOutput({tag, ":state"}, {30'd0, bus.state}, 32'(m_state));
        checkOutput({tag, ":pc_write"}, {31'd0, bus.pc_write}, {31'd0, e_wr});
        checkOutput({tag, ":fetch_req"}, {31'd0, bus.fetch_req}, {31'd0, e_fetch});
        checkOutput({tag, ":epc"}, bus.epc, m_epc);
        checkOutput({tag, ":retired"}, bus.retired, m_retired);
        if (e_wr || (m_state == S_EXEC && bus.stall)) begin
            checkOutput({tag, ":pc_next"}, bus.pc_next, e_next);
        end

        @(posedge clk);
        m_state   = n_state;
        m_epc     = n_epc;
        m_retired = n_ret;
        if (e_wr) m_pc = e_next;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] pc,
                                 input logic rdy, input logic stl,
                                 input logic br, input logic [31:0] bt,
                                 input logic jmp, input logic [31:0] jt,
                                 input logic hlt, input logic iq,
                                 input logic ie);
        bus.pc_cur        = pc;
        bus.imem_ready    = rdy;
        bus.stall         = stl;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = jmp;
        bus.jump_target   = jt;
        bus.halt          = hlt;
        bus.irq           = iq;
        bus.irq_en        = ie;
        runCycle(tag);
    endtask

    task automatic doFetch(input string tag, input logic [31:0] pc, input int waits);
        for (int i = 0; i < waits; i++) begin
            applyStimulus({tag, ":fwait"}, pc, 1'b0, 1'b0, 1'b0, 32'd0,
                          1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus({tag, ":fdone"}, pc, 1'b1, 1'b0, 1'b0, 32'd0,
                      1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modelReset();
        m_state   = S_BOOT;
        m_epc     = 32'd0;
        m_retired = 32'd0;
        m_pc      = 32'd0;
    endtask

    initial begin
        logic [31:0] saved_ret;

        modelReset();
        bus.pc_cur = 32'd0;  bus.imem_ready = 1'b0; bus.stall = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
        bus.jump = 1'b0; bus.jump_target = 32'd0; bus.halt = 1'b0;
        bus.irq = 1'b0; bus.irq_en = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst:state", {30'd0, bus.state}, 32'd0);
        checkOutput("rst:fetch_req", {31'd0, bus.fetch_req}, 32'd0);
        checkOutput("rst:epc", bus.epc, 32'd0);
        checkOutput("rst:retired", bus.retired, 32'd0);
        reset = 1'b1;

        // Boot, slow first fetch, then three sequential instructions.
        applyStimulus("boot", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("boot:literal", last_pc_next, 32'd107);
        doFetch("seq0", 32'd107, 3);
        applyStimulus("seq0x", 32'd107, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("seq0:literal", last_pc_next, 32'd108);
        doFetch("seq1", 32'd108, 0);
        applyStimulus("seq1x", 32'd108, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("seq1:literal", last_pc_next, 32'd109);
        doFetch("seq2", 32'd109, 0);
        applyStimulus("seq2x", 32'd109, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("seq2:literal", last_pc_next, 32'd110);
        checkOutput("seq:retired3", bus.retired, 32'd3);

        // Jump outranks branch.
        doFetch("jb", 32'd110, 1);
        applyStimulus("jbx", 32'd120, 1'b0, 1'b0, 1'b1, 32'd50, 1'b1, 32'd200,
                      1'b0, 1'b0, 1'b0);
        checkOutput("jb:literal", last_pc_next, 32'd200);

        // Interrupt outranks jump and saves the return PC.
        doFetch("irq", 32'd200, 2);
        applyStimulus("irqx", 32'd300, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd200,
                      1'b0, 1'b1, 1'b1);
        checkOutput("irq:literal", last_pc_next, 32'd4);
        checkOutput("irq:epc", bus.epc, 32'd301);
        checkOutput("irq:state", {30'd0, bus.state}, 32'd1);

        // Stall holds everything, even with halt and irq pending.
        doFetch("stl", 32'd4, 0);
        saved_ret = m_retired;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("stlx", 32'd150, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,
                          i[0], i[1], 1'b1);
        end
        checkOutput("stl:retired", bus.retired, saved_ret);
        applyStimulus("stlgo", 32'd150, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("stl:literal", last_pc_next, 32'd151);

        // Branch only; irq with irq_en=0 is ignored.
        doFetch("br", 32'd151, 0);
        applyStimulus("brx", 32'd151, 1'b0, 1'b0, 1'b1, 32'd77, 1'b0, 32'd0,
                      1'b0, 1'b1, 1'b0);
        checkOutput("br:literal", last_pc_next, 32'd77);

        // Sequential wrap at the top of the address space.
        doFetch("wrap", 32'd77, 0);
        applyStimulus("wrapx", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0,
                      32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap:literal", last_pc_next, 32'd0);

        // Halt wins over jump, sits for ten cycles, then an irq wakes it.
        doFetch("hlt", 32'd0, 0);
        applyStimulus("hltx", 32'd90, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd500,
                      1'b1, 1'b0, 1'b0);
        checkOutput("hlt:literal", last_pc_next, 32'd91);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("hltwait", 32'd91, 1'(i % 2), 1'b0, 1'b0, 32'd0, 1'b0,
                          32'd0, 1'b0, 1'(i % 3 == 0), 1'b0);
        end
        applyStimulus("hltirq", 32'd91, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b1, 1'b1);
        checkOutput("hltirq:literal", last_pc_next, 32'd4);
        checkOutput("hltirq:epc", bus.epc, 32'd91);

        // Halt together with an accepted irq: irq wins.
        doFetch("hi", 32'd4, 0);
        applyStimulus("hix", 32'd60, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b1, 1'b1, 1'b1);
        checkOutput("hi:state", {30'd0, bus.state}, 32'd1);
        checkOutput("hi:epc", bus.epc, 32'd61);

        // Randomized traffic with the modelled PC register fed back.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? $urandom : m_pc;
            applyStimulus("rnd", pc,
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 2) == 0), $urandom,
                          1'($urandom_range(0, 3) == 0), $urandom,
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)));
        end

        // Reach FETCH, then assert reset mid-cycle with imem_ready pending.
        for (int i = 0; i < 40 && m_state != S_FETCH; i++) begin
            applyStimulus("tofetch", m_pc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                          1'b0, 1'b1, 1'b1);
        end
        checkOutput("midrst:in_fetch", {30'd0, bus.state}, 32'd1);
        bus.imem_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst:state", {30'd0, bus.state}, 32'd0);
        checkOutput("midrst:retired", bus.retired, 32'd0);
        checkOutput("midrst:epc", bus.epc, 32'd0);
        checkOutput("midrst:fetch_req", {31'd0, bus.fetch_req}, 32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("inrst:state", {30'd0, bus.state}, 32'd0);
        reset = 1'b1;
        applyStimulus("reboot", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0,
                      1'b0, 1'b0, 1'b0);
        checkOutput("reboot:literal", last_pc_next, 32'd107);
        doFetch("reboot", 32'd107, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, mismatch_count);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        mismatch_count++;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, mismatch_count);
        $finish;
    end

endmodule
